// File: rtl/id_ex_stage_if.sv
// id_ex_stage_if: groups the decode-side inputs, the flush request and the
// registered execute-side outputs of the ID/EX pipeline register.
//   master modport: drives id_* and ex_flush, observes ex_* and stall
//   slave  modport: the ID/EX stage itself
interface id_ex_stage_if #(
  parameter int unsigned XLEN = 32
);
  // decode side
  logic            id_valid;
  logic [XLEN-1:0] id_pc;
  logic [XLEN-1:0] id_data1;
  logic [XLEN-1:0] id_data2;
  logic [XLEN-1:0] id_imm;
  logic [4:0]      id_rs1;
  logic [4:0]      id_rs2;
  logic [4:0]      id_rd;
  logic            id_use_rs1;
  logic            id_use_rs2;
  logic            id_regWEn;
  logic            id_memRead;
  logic            id_memWrite;
  logic            id_aluSrc;
  logic [3:0]      id_aluOp;
  logic [1:0]      id_wbSel;
  // flush request from execute
  logic            ex_flush;
  // execute side
  logic            ex_valid;
  logic [XLEN-1:0] ex_pc;
  logic [XLEN-1:0] ex_data1;
  logic [XLEN-1:0] ex_data2;
  logic [XLEN-1:0] ex_imm;
  logic [4:0]      ex_rs1;
  logic [4:0]      ex_rs2;
  logic [4:0]      ex_rd;
  logic            ex_regWEn;
  logic            ex_memRead;
  logic            ex_memWrite;
  logic            ex_aluSrc;
  logic [3:0]      ex_aluOp;
  logic [1:0]      ex_wbSel;
  // hazard stall to fetch/decode
  logic            stall;

  modport master (
    output id_valid, id_pc, id_data1, id_data2, id_imm, id_rs1, id_rs2, id_rd,
           id_use_rs1, id_use_rs2, id_regWEn, id_memRead, id_memWrite,
           id_aluSrc, id_aluOp, id_wbSel, ex_flush,
    input  ex_valid, ex_pc, ex_data1, ex_data2, ex_imm, ex_rs1, ex_rs2, ex_rd,
           ex_regWEn, ex_memRead, ex_memWrite, ex_aluSrc, ex_aluOp, ex_wbSel,
           stall
  );

  modport slave (
    input  id_valid, id_pc, id_data1, id_data2, id_imm, id_rs1, id_rs2, id_rd,
           id_use_rs1, id_use_rs2, id_regWEn, id_memRead, id_memWrite,
           id_aluSrc, id_aluOp, id_wbSel, ex_flush,
    output ex_valid, ex_pc, ex_data1, ex_data2, ex_imm, ex_rs1, ex_rs2, ex_rd,
           ex_regWEn, ex_memRead, ex_memWrite, ex_aluSrc, ex_aluOp, ex_wbSel,
           stall
  );
endinterface

// File: rtl/id_ex_stage.sv
// id_ex_stage: ID/EX pipeline register with load-use hazard detection and
// branch/jump flush handling.
//   clk       : clock, all state on posedge
//   rst       : synchronous active-high reset (loads a bubble)
//   bus       : id_ex_stage_if.slave (id_* in, ex_flush in, ex_* out, stall out)
//   stall_cnt : cycles with stall asserted  (only with PERF_CNT_EN)
//   flush_cnt : cycles with ex_flush asserted (only with PERF_CNT_EN)
// Optional feature macro: PERF_CNT_EN (performance counters).
module id_ex_stage #(
  parameter int unsigned XLEN = 32
) (
  input  logic               clk,
  input  logic               rst,
  id_ex_stage_if.slave       bus
`ifdef PERF_CNT_EN
  ,
  output logic [31:0]        stall_cnt,
  output logic [31:0]        flush_cnt
`endif
);

  logic            valid_q,    valid_d;
  logic [XLEN-1:0] pc_q,       pc_d;
  logic [XLEN-1:0] data1_q,    data1_d;
  logic [XLEN-1:0] data2_q,    data2_d;
  logic [XLEN-1:0] imm_q,      imm_d;
  logic [4:0]      rs1_q,      rs1_d;
  logic [4:0]      rs2_q,      rs2_d;
  logic [4:0]      rd_q,       rd_d;
  logic            regWEn_q,   regWEn_d;
  logic            memRead_q,  memRead_d;
  logic            memWrite_q, memWrite_d;
  logic            aluSrc_q,   aluSrc_d;
  logic [3:0]      aluOp_q,    aluOp_d;
  logic [1:0]      wbSel_q,    wbSel_d;

  logic load_use;
  logic capture;

  // x0 is never a real destination, so a load into it cannot cause a hazard.
  always_comb begin
    load_use = valid_q & memRead_q & (rd_q != 5'd0) & bus.id_valid &
               ((bus.id_use_rs1 & (bus.id_rs1 == rd_q)) |
                (bus.id_use_rs2 & (bus.id_rs2 == rd_q)));
  end

  // A flush discards the decode slot anyway, so there is nothing to hold.
  assign bus.stall = load_use & ~bus.ex_flush;
  assign capture   = ~bus.ex_flush & ~load_use;

  // Default is a bubble; id_valid=0 is passed through with its control bits.
  always_comb begin
    valid_d    = 1'b0;
    pc_d       = '0;
    data1_d    = '0;
    data2_d    = '0;
    imm_d      = '0;
    rs1_d      = '0;
    rs2_d      = '0;
    rd_d       = '0;
    regWEn_d   = 1'b0;
    memRead_d  = 1'b0;
    memWrite_d = 1'b0;
    aluSrc_d   = 1'b0;
    aluOp_d    = '0;
    wbSel_d    = '0;
    if (capture) begin
      valid_d    = bus.id_valid;
      pc_d       = bus.id_pc;
      data1_d    = bus.id_data1;
      data2_d    = bus.id_data2;
      imm_d      = bus.id_imm;
      rs1_d      = bus.id_rs1;
      rs2_d      = bus.id_rs2;
      rd_d       = bus.id_rd;
      regWEn_d   = bus.id_regWEn;
      memRead_d  = bus.id_memRead;
      memWrite_d = bus.id_memWrite;
      aluSrc_d   = bus.id_aluSrc;
      aluOp_d    = bus.id_aluOp;
      wbSel_d    = bus.id_wbSel;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      valid_q    <= 1'b0;
      pc_q       <= '0;
      data1_q    <= '0;
      data2_q    <= '0;
      imm_q      <= '0;
      rs1_q      <= '0;
      rs2_q      <= '0;
      rd_q       <= '0;
      regWEn_q   <= 1'b0;
      memRead_q  <= 1'b0;
      memWrite_q <= 1'b0;
      aluSrc_q   <= 1'b0;
      aluOp_q    <= '0;
      wbSel_q    <= '0;
    end else begin
      valid_q    <= valid_d;
      pc_q       <= pc_d;
      data1_q    <= data1_d;
      data2_q    <= data2_d;
      imm_q      <= imm_d;
      rs1_q      <= rs1_d;
      rs2_q      <= rs2_d;
      rd_q       <= rd_d;
      regWEn_q   <= regWEn_d;
      memRead_q  <= memRead_d;
      memWrite_q <= memWrite_d;
      aluSrc_q   <= aluSrc_d;
      aluOp_q    <= aluOp_d;
      wbSel_q    <= wbSel_d;
    end
  end

  assign bus.ex_valid    = valid_q;
  assign bus.ex_pc       = pc_q;
  assign bus.ex_data1    = data1_q;
  assign bus.ex_data2    = data2_q;
  assign bus.ex_imm      = imm_q;
  assign bus.ex_rs1      = rs1_q;
  assign bus.ex_rs2      = rs2_q;
  assign bus.ex_rd       = rd_q;
  assign bus.ex_regWEn   = regWEn_q;
  assign bus.ex_memRead  = memRead_q;
  assign bus.ex_memWrite = memWrite_q;
  assign bus.ex_aluSrc   = aluSrc_q;
  assign bus.ex_aluOp    = aluOp_q;
  assign bus.ex_wbSel    = wbSel_q;

`ifdef PERF_CNT_EN
  logic [31:0] stall_cnt_q, stall_cnt_d;
  logic [31:0] flush_cnt_q, flush_cnt_d;

  // Counters wrap naturally at 2^32.
  always_comb begin
    stall_cnt_d = stall_cnt_q + {31'd0, bus.stall};
    flush_cnt_d = flush_cnt_q + {31'd0, bus.ex_flush};
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      stall_cnt_q <= '0;
      flush_cnt_q <= '0;
    end else begin
      stall_cnt_q <= stall_cnt_d;
      flush_cnt_q <= flush_cnt_d;
    end
  end

  assign stall_cnt = stall_cnt_q;
  assign flush_cnt = flush_cnt_q;
`endif

endmodule
